// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: two byte ports share one 8N1 TX line, round-robin.
// Define SERIAL_TX_PARITY_EN to add an even-parity bit before the stop bit.
module serial_tx_arbiter #(
    parameter int SAMPLE_RATIO = 16
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       dout,
    output logic       busy,
    output logic       grant_id
);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    localparam logic [3:0] LAST = 4'(SAMPLE_RATIO - 1);

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [2:0] bit_count_q, bit_count_d;
    logic [7:0] shift_q, shift_d;
    logic       dout_q, dout_d;
    logic       busy_q, busy_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       grant_id_q, grant_id_d;
    logic       last_served_q, last_served_d;
`ifdef SERIAL_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif
    logic       pick1;
    logic       bit_end;

    // Next-state logic; dout/busy/ack are computed one cycle ahead so they come out registered
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        bit_count_d   = bit_count_q;
        shift_d       = shift_q;
        dout_d        = dout_q;
        busy_d        = busy_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        grant_id_d    = grant_id_q;
        last_served_d = last_served_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d      = parity_q;
`endif
        pick1         = 1'b0;
        bit_end       = (count_q == LAST);
        unique case (state_q)
            IDLE: begin
                dout_d = 1'b1;
                busy_d = 1'b0;
                if (req0 || req1) begin
                    pick1         = req1 && (!req0 || !last_served_q);
                    state_d       = START;
                    count_d       = 4'd0;
                    bit_count_d   = 3'd0;
                    shift_d       = pick1 ? data1 : data0;
                    grant_id_d    = pick1;
                    last_served_d = pick1;
                    ack0_d        = !pick1;
                    ack1_d        = pick1;
                    dout_d        = 1'b0;
                    busy_d        = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d      = ^(pick1 ? data1 : data0);
`endif
                end
            end
            START: begin
                count_d = count_q + 4'd1;
                if (bit_end) begin
                    state_d     = DATA;
                    count_d     = 4'd0;
                    bit_count_d = 3'd0;
                    dout_d      = shift_q[0];
                end
            end
            DATA: begin
                count_d = count_q + 4'd1;
                if (bit_end) begin
                    count_d     = 4'd0;
                    shift_d     = {1'b0, shift_q[7:1]};
                    bit_count_d = bit_count_q + 3'd1;
                    dout_d      = shift_q[1];
                    if (bit_count_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
                        dout_d  = parity_q;
`else
                        state_d = STOP;
                        dout_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                count_d = count_q + 4'd1;
                if (bit_end) begin
                    state_d = STOP;
                    count_d = 4'd0;
                    dout_d  = 1'b1;
                end
            end
`endif
            STOP: begin
                count_d = count_q + 4'd1;
                if (bit_end) begin
                    state_d = IDLE;
                    count_d = 4'd0;
                    dout_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 4'd0;
                dout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight
    always_ff @(posedge sample_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            count_q       <= 4'd0;
            bit_count_q   <= 3'd0;
            shift_q       <= 8'd0;
            dout_q        <= 1'b1;
            busy_q        <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            grant_id_q    <= 1'b0;
            last_served_q <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            bit_count_q   <= bit_count_d;
            shift_q       <= shift_d;
            dout_q        <= dout_d;
            busy_q        <= busy_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            grant_id_q    <= grant_id_d;
            last_served_q <= last_served_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign dout     = dout_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: directed vectors for the shared serial transmitter.
// Frame length follows SERIAL_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_serial_tx_arbiter;

    localparam int SR = 16;
`ifdef SERIAL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, dout, busy, grant_id;
    logic       b_req0, b_req1;
    logic [7:0] b_data0, b_data1;
    logic       b_ack0, b_ack1, b_dout, b_busy, b_gid;

    always #5 clk = ~clk;

    serial_tx_arbiter #(.SAMPLE_RATIO(SR)) dut (
        .sample_clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .dout(dout), .busy(busy), .grant_id(grant_id)
    );

    serial_tx_arbiter #(.SAMPLE_RATIO(2)) dut2 (
        .sample_clk(clk), .reset(reset),
        .req0(b_req0), .data0(b_data0), .ack0(b_ack0),
        .req1(b_req1), .data1(b_data1), .ack1(b_ack1),
        .dout(b_dout), .busy(b_busy), .grant_id(b_gid)
    );

    typedef struct {
        logic       port;
        logic [7:0] data;
        logic [9:0] bits;
        logic       par;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int hi_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (dout === 1'b1) hi_run++;
        else hi_run = 0;
    endtask

    function automatic logic exp_bit(input logic [9:0] bits, input logic par, input int b);
        if (b == NBITS - 1) return 1'b1;
        if (b < 9) return bits[b];
        return par;
    endfunction

    // Called at the sample showing the ack; walks the whole frame plus the idle cycle
    task automatic check_frame(input string name, input logic port,
                               input logic [9:0] bits, input logic par);
        int bad_ack;
        int bad_busy;
        int bad_gid;
        bad_ack = 0;
        bad_busy = 0;
        bad_gid = 0;
        for (int b = 0; b < NBITS; b++) begin
            int bad;
            bad = 0;
            for (int c = 0; c < SR; c++) begin
                if (b != 0 || c != 0) step();
                if (dout !== exp_bit(bits, par, b)) bad++;
                if (busy !== 1'b1) bad_busy++;
                if (grant_id !== port) bad_gid++;
                if ((b != 0 || c != 0) && (ack0 | ack1) !== 1'b0) bad_ack++;
            end
            chk($sformatf("%s bit%0d", name, b), bad, 0);
        end
        chk({name, " busy"}, bad_busy, 0);
        chk({name, " gid"}, bad_gid, 0);
        chk({name, " extra ack"}, bad_ack, 0);
        step();
        chk({name, " idle dout"}, dout, 1);
        chk({name, " idle busy"}, busy, 0);
        chk({name, " idle gid"}, grant_id, port);
    endtask

    task automatic send(input string name, input logic port, input logic [7:0] d);
        if (port) begin
            req1 = 1'b1;
            data1 = d;
        end else begin
            req0 = 1'b1;
            data0 = d;
        end
        step();
        chk({name, " ack0"}, ack0, !port);
        chk({name, " ack1"}, ack1, port);
        chk({name, " start"}, dout, 0);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        int   cnt_a, cnt_b;

        tbl[0] = '{1'b0, 8'hA5, 10'h34A, 1'b0};
        tbl[1] = '{1'b1, 8'h3C, 10'h278, 1'b0};
        tbl[2] = '{1'b0, 8'h81, 10'h302, 1'b0};
        tbl[3] = '{1'b1, 8'h07, 10'h20E, 1'b1};
        tbl[4] = '{1'b0, 8'h03, 10'h206, 1'b0};
        tbl[5] = '{1'b1, 8'hFF, 10'h3FE, 1'b0};

        reset = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        b_req0 = 1'b0;
        b_req1 = 1'b0;
        b_data0 = 8'h00;
        b_data1 = 8'h00;
        repeat (3) step();
        chk("rst dout", dout, 1);
        chk("rst busy", busy, 0);
        chk("rst ack", {ack0, ack1}, 0);
        chk("rst gid", grant_id, 0);
        chk("rst dout2", b_dout, 1);
        reset = 1'b0;
        step();
        chk("idle dout", dout, 1);

        for (int i = 0; i < 6; i++) begin
            send($sformatf("vec%0d", i), tbl[i].port, tbl[i].data);
            check_frame($sformatf("vec%0d", i), tbl[i].port, tbl[i].bits, tbl[i].par);
        end

        // Tie: last served was port 1, so port 0 goes first
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 8'h00;
        data1 = 8'hFF;
        step();
        chk("rr1 ack0", ack0, 1);
        chk("rr1 ack1", ack1, 0);
        check_frame("rr1", 1'b0, 10'h200, 1'b0);
        chk("rr gap", hi_run, SR + 1);
        step();
        chk("rr2 ack0", ack0, 0);
        chk("rr2 ack1", ack1, 1);
        check_frame("rr2", 1'b1, 10'h3FE, 1'b0);
        step();
        chk("rr3 ack0", ack0, 1);
        chk("rr3 ack1", ack1, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        check_frame("rr3", 1'b0, 10'h200, 1'b0);

        // Short req1 pulse mid-frame is dropped
        send("pulse", 1'b0, 8'h5A);
        cnt_a = 0;
        for (int k = 1; k <= NBITS * SR + 20; k++) begin
            if (k == 50) req1 = 1'b1;
            if (k == 51) req1 = 1'b0;
            step();
            if (ack0 | ack1) cnt_a++;
        end
        chk("pulse no ack", cnt_a, 0);
        chk("pulse busy", busy, 0);

        // Held req1 is granted right after the frame
        send("hold", 1'b0, 8'hC3);
        cnt_a = 0;
        for (int k = 1; k <= NBITS * SR; k++) begin
            if (k == 60) begin
                req1 = 1'b1;
                data1 = 8'h96;
            end
            step();
            if (ack1) cnt_a++;
        end
        chk("hold early ack", cnt_a, 0);
        chk("hold idle busy", busy, 0);
        step();
        chk("hold ack1", ack1, 1);
        req1 = 1'b0;
        check_frame("hold", 1'b1, 10'h32C, 1'b0);

        // Reset during data bit 3 of a port-1 frame
        send("mid", 1'b1, 8'hA5);
        repeat (4 * SR + 5) step();
        chk("mid busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid rst dout", dout, 1);
        chk("mid rst busy", busy, 0);
        chk("mid rst gid", grant_id, 0);
        chk("mid rst ack", {ack0, ack1}, 0);
        cnt_a = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if ((ack0 | ack1 | !dout | busy) !== 1'b0) cnt_a++;
        end
        chk("mid quiet", cnt_a, 0);
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 8'h3C;
        data1 = 8'h81;
        step();
        chk("post rst ack0", ack0, 1);
        chk("post rst ack1", ack1, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        check_frame("post rst", 1'b0, 10'h278, 1'b0);
        send("post req1", 1'b1, 8'h81);
        check_frame("post req1", 1'b1, 10'h302, 1'b0);

        // Two cycles per bit
        b_req0 = 1'b1;
        b_data0 = 8'h01;
        step();
        chk("sr2 ack0", b_ack0, 1);
        b_req0 = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int s = 0; s < 2 * NBITS; s++) begin
            if (s != 0) step();
            if (b_dout !== exp_bit(10'h202, 1'b1, s / 2)) cnt_a++;
            if (b_busy === 1'b1) cnt_b++;
        end
        chk("sr2 bits", cnt_a, 0);
        chk("sr2 busy len", cnt_b, 2 * NBITS);
        step();
        chk("sr2 idle busy", b_busy, 0);
        chk("sr2 idle dout", b_dout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one 8N1 serial transmit line between two byte requesters (port 0, port 1) using round-robin arbitration.
- Each granted byte is serialized as a start bit, 8 data bits LSB first, and a stop bit.
- Each bit lasts SAMPLE_RATIO cycles of sample_clk, so the output matches the receive-side oversampling rate on the same clock.
- Sits on the transmit side of the serial transceiver, between on-chip byte producers and the TX pin.

Parameters:
- SAMPLE_RATIO, 16: sample_clk cycles per serial bit. Legal range 2..16; the bit-period counter is 4 bits wide.

Ports:
- sample_clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  port 0 requests transmission of data0.
- data0  input  8  port 0 byte; held stable while req0=1 and until ack0.
- ack0  output  1  one-cycle pulse: data0 latched, frame started.
- req1  input  1  port 1 request.
- data1  input  8  port 1 byte.
- ack1  output  1  one-cycle pulse for port 1.
- dout  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.
- grant_id  output  1  owner of the current or most recent frame.

Behaviour:
- Reset: dout=1, busy=0, ack0=ack1=0, grant_id=0, last_served=1 (port 0 wins the first tie), state=IDLE, count=0, bit_count=0, shift register=0.
- Reset mid-frame: dout=1 on the next edge, the frame is abandoned, no ack is reissued, and the requester must re-request.
- All outputs are registered.
- States: IDLE, START, DATA, STOP (optionally PARITY, see Optional Feature).
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - Only one request asserted: grant that port.
  - Both asserted: grant the port != last_served.
  - On grant at edge N: latch the byte, set grant_id and last_served, state=START, count=0.
  - In cycle N+1: dout=0, busy=1, and ack of the granted port=1 for exactly that cycle.
  - No request: remain in IDLE with dout=1.
- START: dout=0 for SAMPLE_RATIO cycles, then DATA with bit_count=0.
- DATA:
  - dout=shift[0] for SAMPLE_RATIO cycles per bit.
  - At the end of each bit: shift right, bit_count+1.
  - After bit_count reaches 7 and its period ends, go to STOP.
- STOP: dout=1 for SAMPLE_RATIO cycles, then IDLE.
- Bit periods: count runs 0..SAMPLE_RATIO-1 within each bit and wraps to 0 at each bit boundary.
- Frame timing:
  - dout low for exactly SAMPLE_RATIO cycles at the start bit.
  - Total frame is 10*SAMPLE_RATIO cycles from the dout falling edge to the end of the stop bit.
  - A mandatory single IDLE cycle follows, so back-to-back frames show a stop high time of SAMPLE_RATIO+1 cycles.
- busy = (state != IDLE), registered alongside the state.
- Requests during a frame are ignored until IDLE. A requester that holds req after its ack is treated as a new request at the next IDLE.
- grant_id holds its value through IDLE until the next grant.
- No combinational path from req/data to dout or ack.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - dout = XOR of the 8 latched data bits (even parity) for SAMPLE_RATIO cycles.
  - Frame is 11*SAMPLE_RATIO cycles.
- Undefined: no PARITY state, and the frame is 10*SAMPLE_RATIO cycles.
- All other behaviour is identical in both builds.

Test Plan:
- Single request, SAMPLE_RATIO=16: reset, then req0=1, data0=8'hA5 for one cycle.
  - ack0 pulses one cycle, coincident with dout falling.
  - dout sequence per 16-cycle period: 0,1,0,1,0,0,1,0,1,1 then idle high.
  - busy high for 160 cycles; grant_id=0.
- Tie, round-robin: req0 and req1 both held with data0=8'h00, data1=8'hFF.
  - First frame on port 0 (ack0), then port 1 (ack1), then port 0.
  - The gap between frames is a high period of 17 cycles.
- Request during frame: req1 pulses mid-frame of port 0 then drops.
  - No ack1 and no port 1 frame.
  - req1 held until IDLE is granted immediately after the current frame.
- Reset mid-frame: assert reset during data bit 3.
  - Next edge: dout=1, busy=0, grant_id=0, no ack.
  - A subsequent req1 is granted: last_served reset to 1 makes port 0 win ties, and with only req1 asserted, port 1 is granted.
- SAMPLE_RATIO=2, byte 8'h01: each bit lasts exactly 2 cycles; frame is 20 cycles.
- SERIAL_TX_PARITY_EN defined:
  - 8'h07 gives parity bit 1; 8'h03 gives parity bit 0.
  - Frame is 176 cycles at SAMPLE_RATIO=16.
